// File: rtl/dma_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_sched_pkg
// Description : Shared FSM encoding, default frame geometry and address helper
//               for the DMA write frame scheduler.
// Revision    : 1.0
// ============================================================================
package dma_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_CMD      = 3'd2,
        ST_XFER     = 3'd3,
        ST_DONE     = 3'd4
    } sched_state_t;

    localparam logic [31:0] c_DEF_FRAME_BYTES = 32'd1843200;
    localparam logic [31:0] c_DEF_BUF_STRIDE  = 32'h0040_0000;

    // Address arithmetic intentionally wraps modulo 2^32.
    function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [1:0]  idx);
        return base + stride * {30'd0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/buf_sel.sv
`default_nettype none
// ============================================================================
// Module      : buf_sel
// Description : Picks the next write buffer, skipping the one held by the reader.
// Revision    : 1.0
// ============================================================================
module buf_sel #(
    parameter int BUF_NUM = 3
) (
    input  logic [1:0] cur_idx,
    input  logic       rd_lock,
    input  logic [1:0] rd_buf_idx,
    output logic [1:0] next_idx
);

    localparam logic [1:0] c_LAST = 2'(BUF_NUM - 1);

    logic [1:0] w_cand;
    logic [1:0] w_skip;

    assign w_cand = (cur_idx == c_LAST) ? 2'd0 : cur_idx + 2'd1;
    assign w_skip = (w_cand == c_LAST) ? 2'd0 : w_cand + 2'd1;

    // With only two buffers there is nowhere to skip to, so overwrite the current one.
    always_comb begin
        next_idx = w_cand;
        if (rd_lock && (w_cand == rd_buf_idx)) begin
            next_idx = (BUF_NUM == 2) ? cur_idx : w_skip;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_wr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : dma_wr_frame_sched
// Description : Schedules one DMA write command per camera frame into a ring
//               of frame buffers, avoiding the buffer held by the reader.
// Revision    : 1.0
// ============================================================================
module dma_wr_frame_sched
    import dma_sched_pkg::*;
#(
    parameter int          ID_WIDTH    = 4,
    parameter int          BUF_NUM     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] BUF_STRIDE  = c_DEF_BUF_STRIDE,
    parameter logic [31:0] FRAME_BYTES = c_DEF_FRAME_BYTES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                frame_start,
    output logic                cmd_valid,
    output logic [31:0]         cmd_addr,
    output logic [31:0]         cmd_len,
    output logic [ID_WIDTH-1:0] cmd_id,
    input  logic                cmd_ready,
    input  logic                dma_done,
    input  logic                rd_lock,
    input  logic [1:0]          rd_buf_idx,
    output logic                done_valid,
    output logic [1:0]          done_idx,
    output logic                busy,
    output logic [15:0]         drop_cnt
);

    localparam logic [1:0] c_LAST_IDX = 2'(BUF_NUM - 1);

    sched_state_t r_state;
    logic [1:0]   r_wr_idx;
    logic [1:0]   w_next_idx;
    logic         w_drop_evt;

    buf_sel #(
        .BUF_NUM    (BUF_NUM)
    ) u_buf_sel (
        .cur_idx    (r_wr_idx),
        .rd_lock    (rd_lock),
        .rd_buf_idx (rd_buf_idx),
        .next_idx   (w_next_idx)
    );

    // Frames arriving while one is in flight are dropped, not queued.
    assign w_drop_evt = frame_start &&
                        ((r_state == ST_CMD) || (r_state == ST_XFER) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wr_idx   <= c_LAST_IDX;
            cmd_valid  <= 1'b0;
            cmd_addr   <= BASE_ADDR;
            cmd_len    <= 32'd0;
            cmd_id     <= '0;
            done_valid <= 1'b0;
            done_idx   <= 2'd0;
            busy       <= 1'b0;
            drop_cnt   <= 16'd0;
        end else begin
            done_valid <= 1'b0;
            if (w_drop_evt && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (frame_start) begin
                        r_wr_idx  <= w_next_idx;
                        cmd_addr  <= buf_addr(BASE_ADDR, BUF_STRIDE, w_next_idx);
                        cmd_len   <= FRAME_BYTES;
                        cmd_id    <= ID_WIDTH'(w_next_idx);
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        r_state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (dma_done) begin
                        done_idx   <= r_wr_idx;
                        done_valid <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= enable ? ST_WAIT_SOF : ST_IDLE;
                end
                default: begin
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_wr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_wr_frame_sched
// Description : Self-checking bench for dma_wr_frame_sched with a frame-level model.
// Revision    : 1.0
// ============================================================================
module tb_dma_wr_frame_sched;

    localparam int          ID_WIDTH = 4;
    localparam int          BUF_NUM  = 3;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam logic [31:0] STRIDE   = 32'h0040_0000;
    localparam logic [31:0] FBYTES   = 32'd1843200;

    logic                clk = 1'b0;
    logic                rst_n, enable, frame_start, cmd_ready, dma_done, rd_lock;
    logic [1:0]          rd_buf_idx;
    logic                cmd_valid, done_valid, busy;
    logic [31:0]         cmd_addr, cmd_len;
    logic [ID_WIDTH-1:0] cmd_id;
    logic [1:0]          done_idx;
    logic [15:0]         drop_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int m_wr;
    int m_drop;

    always #5 clk = ~clk;

    dma_wr_frame_sched #(
        .ID_WIDTH    (ID_WIDTH),
        .BUF_NUM     (BUF_NUM),
        .BASE_ADDR   (BASE),
        .BUF_STRIDE  (STRIDE),
        .FRAME_BYTES (FBYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_start (frame_start),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_id      (cmd_id),
        .cmd_ready   (cmd_ready),
        .dma_done    (dma_done),
        .rd_lock     (rd_lock),
        .rd_buf_idx  (rd_buf_idx),
        .done_valid  (done_valid),
        .done_idx    (done_idx),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    // Ring of buffers: advance by one, hop over the reader's buffer if possible.
    function automatic int model_pick(int cur, bit lock, int rdi);
        int cand;
        cand = (cur + 1) % BUF_NUM;
        if (lock && cand == rdi) return (BUF_NUM == 2) ? cur : (cand + 1) % BUF_NUM;
        return cand;
    endfunction

    function automatic logic [31:0] model_addr(int idx);
        return BASE + STRIDE * 32'(idx);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; cmd_ready = 1'b0;
        dma_done = 1'b0; rd_lock = 1'b0; rd_buf_idx = 2'd0;
        step();
        step();
        rst_n  = 1'b1;
        m_wr   = BUF_NUM - 1;
        m_drop = 0;
    endtask

    task automatic frame_to_cmd(input bit lock, input logic [1:0] rdi);
        frame_start = 1'b1; rd_lock = lock; rd_buf_idx = rdi;
        step();
        frame_start = 1'b0; rd_lock = 1'b0;
        m_wr = model_pick(m_wr, lock, int'(rdi));
    endtask

    task automatic finish_frame();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        step();
        dma_done = 1'b1; step(); dma_done = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; cmd_ready = 1'b0;
        dma_done = 1'b0; rd_lock = 1'b0; rd_buf_idx = 2'd0;
        step();
        vectors++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || done_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_flags: got v=%b b=%b d=%b want 0 0 0", cmd_valid, busy, done_valid); end
        vectors++; if (cmd_addr !== BASE || cmd_len !== 32'd0) begin
            miscompares++; $display("FAIL rst_cmd: got addr=%0h len=%0d want %0h 0", cmd_addr, cmd_len, BASE); end
        vectors++; if (cmd_id !== '0 || done_idx !== 2'd0 || drop_cnt !== 16'd0) begin
            miscompares++; $display("FAIL rst_misc: got id=%0d didx=%0d drop=%0d want 0 0 0", cmd_id, done_idx, drop_cnt); end
        rst_n = 1'b1;
        m_wr = BUF_NUM - 1; m_drop = 0;
    endtask

    task automatic test_single_frame();
        do_reset();
        enable = 1'b1; step();
        frame_start = 1'b1; cmd_ready = 1'b1; step(); frame_start = 1'b0;
        vectors++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h0) begin
            miscompares++; $display("FAIL sf_cmd: got v=%b addr=%0h want 1 0", cmd_valid, cmd_addr); end
        vectors++; if (cmd_len !== 32'd1843200 || cmd_id !== 4'd0) begin
            miscompares++; $display("FAIL sf_len_id: got len=%0d id=%0d want 1843200 0", cmd_len, cmd_id); end
        step(); cmd_ready = 1'b0;
        vectors++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL sf_xfer: got v=%b busy=%b want 0 1", cmd_valid, busy); end
        dma_done = 1'b1; step(); dma_done = 1'b0;
        vectors++; if (done_valid !== 1'b1 || done_idx !== 2'd0) begin
            miscompares++; $display("FAIL sf_done: got dv=%b idx=%0d want 1 0", done_valid, done_idx); end
        step();
        vectors++; if (done_valid !== 1'b0) begin
            miscompares++; $display("FAIL sf_pulse: got dv=%b want 0", done_valid); end
        m_wr = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h0, 32'h0040_0000, 32'h0080_0000, 32'h0};
        do_reset();
        enable = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            frame_to_cmd(1'b0, 2'd0);
            vectors++; if (cmd_addr !== exp_addr[i] || cmd_addr !== model_addr(m_wr)) begin
                miscompares++; $display("FAIL b2b_addr[%0d]: got %0h want %0h", i, cmd_addr, exp_addr[i]); end
            finish_frame();
        end
    endtask

    task automatic test_rd_lock();
        do_reset();
        enable = 1'b1; step();
        frame_to_cmd(1'b0, 2'd0);
        finish_frame();
        frame_to_cmd(1'b1, 2'd1);
        vectors++; if (cmd_addr !== 32'h0080_0000 || cmd_id !== 4'd2) begin
            miscompares++; $display("FAIL lock_skip: got addr=%0h id=%0d want 800000 2", cmd_addr, cmd_id); end
        finish_frame();
        vectors++; if (done_idx !== 2'd2) begin
            miscompares++; $display("FAIL lock_done_idx: got %0d want 2", done_idx); end
    endtask

    task automatic test_backpressure_drop();
        do_reset();
        enable = 1'b1; step();
        frame_to_cmd(1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h0) begin
                miscompares++; $display("FAIL bp_hold[%0d]: got v=%b addr=%0h want 1 0", i, cmd_valid, cmd_addr); end
        end
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        frame_start = 1'b1; step(); frame_start = 1'b0; step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        vectors++; if (drop_cnt !== 16'd2 || cmd_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL bp_drop2: got drop=%0d v=%b busy=%b want 2 0 1", drop_cnt, cmd_valid, busy); end
        frame_start = 1'b1; dma_done = 1'b1; step(); frame_start = 1'b0; dma_done = 1'b0;
        vectors++; if (done_valid !== 1'b1 || drop_cnt !== 16'd3) begin
            miscompares++; $display("FAIL bp_same_cycle: got dv=%b drop=%0d want 1 3", done_valid, drop_cnt); end
        step();
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        enable = 1'b1; step();
        frame_to_cmd(1'b0, 2'd0);
        finish_frame();
        frame_to_cmd(1'b0, 2'd0);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0; step();
        vectors++; if (busy !== 1'b1 || cmd_addr !== 32'h0040_0000) begin
            miscompares++; $display("FAIL rx_pre: got busy=%b addr=%0h want 1 400000", busy, cmd_addr); end
        #2; rst_n = 1'b0; #1;
        vectors++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || cmd_addr !== BASE) begin
            miscompares++; $display("FAIL rx_async: got v=%b busy=%b addr=%0h want 0 0 0", cmd_valid, busy, cmd_addr); end
        step(); rst_n = 1'b1;
        m_wr = BUF_NUM - 1; m_drop = 0;
        step();
        frame_to_cmd(1'b0, 2'd0);
        vectors++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h0 || cmd_id !== 4'd0) begin
            miscompares++; $display("FAIL rx_restart: got v=%b addr=%0h id=%0d want 1 0 0", cmd_valid, cmd_addr, cmd_id); end
        finish_frame();
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1; step();
        frame_to_cmd(1'b0, 2'd0);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        enable = 1'b0; step();
        dma_done = 1'b1; step(); dma_done = 1'b0;
        vectors++; if (done_valid !== 1'b1 || done_idx !== 2'd0) begin
            miscompares++; $display("FAIL en_done: got dv=%b idx=%0d want 1 0", done_valid, done_idx); end
        step();
        vectors++; if (busy !== 1'b0 || done_valid !== 1'b0) begin
            miscompares++; $display("FAIL en_idle: got busy=%b dv=%b want 0 0", busy, done_valid); end
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1; step(); frame_start = 1'b0; step();
        end
        vectors++; if (drop_cnt !== 16'd0 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL en_ignore: got drop=%0d v=%b busy=%b want 0 0 0", drop_cnt, cmd_valid, busy); end
    endtask

    task automatic test_random();
        bit         lock;
        logic [1:0] rdi;
        do_reset();
        enable = 1'b1; step();
        for (int f = 0; f < 25; f++) begin
            lock = 1'($urandom_range(0, 1));
            rdi  = 2'($urandom_range(0, BUF_NUM - 1));
            frame_to_cmd(lock, rdi);
            vectors++; if (cmd_addr !== model_addr(m_wr) || cmd_id !== ID_WIDTH'(m_wr)) begin
                miscompares++; $display("FAIL rnd_cmd[%0d]: got addr=%0h id=%0d want %0h %0d", f, cmd_addr, cmd_id, model_addr(m_wr), m_wr); end
            repeat ($urandom_range(0, 3)) begin
                frame_start = 1'($urandom_range(0, 1)); if (frame_start) m_drop++;
                step();
            end
            frame_start = 1'b0;
            cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                frame_start = 1'($urandom_range(0, 1)); if (frame_start) m_drop++;
                step();
            end
            frame_start = 1'($urandom_range(0, 1)); if (frame_start) m_drop++;
            dma_done = 1'b1; step(); dma_done = 1'b0; frame_start = 1'b0;
            vectors++; if (done_valid !== 1'b1 || done_idx !== 2'(m_wr)) begin
                miscompares++; $display("FAIL rnd_done[%0d]: got dv=%b idx=%0d want 1 %0d", f, done_valid, done_idx, m_wr); end
            frame_start = 1'($urandom_range(0, 1)); if (frame_start) m_drop++;
            step(); frame_start = 1'b0;
        end
        vectors++; if (drop_cnt !== 16'(m_drop)) begin
            miscompares++; $display("FAIL rnd_drop: got %0d want %0d", drop_cnt, m_drop); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_rd_lock();
        test_backpressure_drop();
        test_reset_mid_xfer();
        test_enable_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
